// File: rtl/leds_arbiter_if.sv
// leds_arbiter_if: requester and LED-register bundle of the LED arbiter.
// The arbiter connects through the slave modport. The requester/LED side connects through master.
interface leds_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = 2
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] req_val;
    logic [N_REQ-1:0]    ack;
    logic                led_start;
    logic [15:0]         led_val;
    logic [OWNER_W-1:0]  owner;
    logic                busy;

    modport master (
        output req, req_val,
        input  ack, led_start, led_val, owner, busy
    );

    modport slave (
        input  req, req_val,
        output ack, led_start, led_val, owner, busy
    );
endinterface

// File: rtl/leds_arbiter.sv
// leds_arbiter: shares one 16-bit LED register between N_REQ requesters.
// Arbitration is round-robin. Each grant produces one write strobe.
// The granted value then stays on the LEDs for at least HOLD_CYCLES cycles.
// Optional build macro LEDS_ARB_PRIO0_EN gives requester 0 fixed top priority.
// With that macro, a request from requester 0 also cuts a running hold short.
module leds_arbiter #(
    parameter int N_REQ       = 4,
    parameter int OWNER_W     = 2,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic          clock,
    input  logic          reset,
    leds_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [OWNER_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [OWNER_W-1:0] win_q,       win_d;
    logic [N_REQ-1:0]   ack_q,       ack_d;
    logic               led_start_q, led_start_d;
    logic [15:0]        led_val_q,   led_val_d;
    logic [OWNER_W-1:0] owner_q,     owner_d;
    logic               busy_q,      busy_d;

    logic               sel_found;
    logic [OWNER_W-1:0] sel_idx;
    logic [OWNER_W-1:0] ptr_after_win;
    int                 scan_k;
`ifdef LEDS_ARB_PRIO0_EN
    int                 prio_base;
`endif

    // The pointer moves just past the winner, wrapping from the last requester to 0.
    assign ptr_after_win = (win_q == OWNER_W'(N_REQ - 1)) ? '0 : win_q + OWNER_W'(1);

    // Winner selection: the first requesting index found while scanning from rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_k    = 0;
`ifdef LEDS_ARB_PRIO0_EN
        // The rotation covers indices 1..N_REQ-1 only. A pointer of 0 starts the scan at index 1.
        prio_base = (rr_ptr_q == '0) ? 0 : int'(rr_ptr_q) - 1;
        if (bus.req[0]) begin
            sel_found = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ - 1; i++) begin
                scan_k = 1 + ((prio_base + i) % (N_REQ - 1));
                if (!sel_found && bus.req[scan_k]) begin
                    sel_found = 1'b1;
                    sel_idx   = OWNER_W'(scan_k);
                end
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            scan_k = (int'(rr_ptr_q) + i) % N_REQ;
            if (!sel_found && bus.req[scan_k]) begin
                sel_found = 1'b1;
                sel_idx   = OWNER_W'(scan_k);
            end
        end
`endif
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        ack_d       = '0;
        led_start_d = 1'b0;
        led_val_d   = led_val_q;
        owner_d     = owner_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (sel_found) begin
                    // Capture the value now so later changes by the requester are not seen.
                    state_d          = S_ISSUE;
                    win_d            = sel_idx;
                    led_start_d      = 1'b1;
                    led_val_d        = bus.req_val[16*int'(sel_idx) +: 16];
                    ack_d[sel_idx]   = 1'b1;
                    owner_d          = sel_idx;
                    busy_d           = 1'b1;
                end
            end

            S_ISSUE: begin
`ifdef LEDS_ARB_PRIO0_EN
                if (win_q != '0) begin
                    rr_ptr_d = ptr_after_win;
                end
`else
                rr_ptr_d = ptr_after_win;
`endif
                cnt_d = CNT_W'(HOLD_CYCLES);
                if (HOLD_CYCLES == 0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_HOLD;
                    busy_d  = 1'b1;
                end
            end

            S_HOLD: begin
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
`ifdef LEDS_ARB_PRIO0_EN
                if (bus.req[0]) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears all of them, so no strobe follows reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            ack_q       <= '0;
            led_start_q <= 1'b0;
            led_val_q   <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop sees the value from before the edge.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            ack_q       <= ack_d;
            led_start_q <= led_start_d;
            led_val_q   <= led_val_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.led_start = led_start_q;
    assign bus.led_val   = led_val_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_leds_arbiter.sv
// tb_leds_arbiter: directed and random checks of leds_arbiter in the default round-robin build.
// The reference model is a grant timeline. Once the arbiter is free, the first requester from
// the rotation pointer wins. The next sample happens HOLD+2 edges later, and busy covers HOLD+1 cycles.
module tb_leds_arbiter;

    localparam int N_REQ   = 4;
    localparam int OWNER_W = 2;
    localparam int HOLD    = 4;
    localparam int CNT_W   = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [N_REQ-1:0]    req_drv = '0;
    logic [16*N_REQ-1:0] val_drv = '0;
    logic [N_REQ-1:0]    drop_on_ack = '1;

    leds_arbiter_if #(.N_REQ(N_REQ), .OWNER_W(OWNER_W)) bus ();

    assign bus.req     = req_drv;
    assign bus.req_val = val_drv;

    leds_arbiter #(
        .N_REQ      (N_REQ),
        .OWNER_W    (OWNER_W),
        .HOLD_CYCLES(HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // Model state and expected outputs
    int               cyc = 0;
    int               free_at = 0;
    int               busy_until = -1;
    int               ptr = 0;
    logic             exp_start = 1'b0;
    logic [N_REQ-1:0] exp_ack = '0;
    logic [15:0]      exp_val = '0;
    logic [OWNER_W-1:0] exp_owner = '0;
    logic             exp_busy = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Log of observed strobes
    int          log_cyc[$];
    int          log_owner[$];
    logic [15:0] log_val[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int i, input logic [15:0] v);
        val_drv[16*i +: 16] = v;
    endtask

    task automatic model_edge();
        cyc++;
        exp_start = 1'b0;
        exp_ack   = '0;
        if (reset) begin
            exp_val    = '0;
            exp_owner  = '0;
            exp_busy   = 1'b0;
            ptr        = 0;
            free_at    = cyc + 1;
            busy_until = -1;
        end else begin
            if (cyc >= free_at && req_drv != '0) begin
                int w;
                w = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    int c;
                    c = (ptr + k) % N_REQ;
                    if (w < 0 && req_drv[c]) w = c;
                end
                exp_start  = 1'b1;
                exp_ack[w] = 1'b1;
                exp_val    = val_drv[16*w +: 16];
                exp_owner  = OWNER_W'(w);
                ptr        = (w + 1) % N_REQ;
                busy_until = cyc + HOLD;
                free_at    = cyc + HOLD + 2;
            end
            exp_busy = (cyc <= busy_until);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("led_start", 32'(bus.led_start), 32'(exp_start));
        check("ack",       32'(bus.ack),       32'(exp_ack));
        check("busy",      32'(bus.busy),      32'(exp_busy));
        check("led_val",   32'(bus.led_val),   32'(exp_val));
        check("owner",     32'(bus.owner),     32'(exp_owner));
        if (bus.led_start === 1'b1) begin
            log_cyc.push_back(cyc);
            log_owner.push_back(int'(bus.owner));
            log_val.push_back(bus.led_val);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_ack[i] && drop_on_ack[i]) req_drv[i] = 1'b0;
        end
    endtask

    initial begin
        int n0;
        int g;
        int got;
        int seen;
        int busy_cnt;

        // Reset state
        repeat (3) cycle();
        #2 reset = 1'b0;
        repeat (2) cycle();

        // Round robin: all four requesters held, grants must follow 0,1,2,3,0
        set_val(0, 16'h0001);
        set_val(1, 16'h0002);
        set_val(2, 16'h0004);
        set_val(3, 16'h0008);
        drop_on_ack = '0;
        req_drv     = '1;
        log_cyc.delete();
        log_owner.delete();
        log_val.delete();
        for (int k = 0; k < 5 * (HOLD + 2) + 4 && log_cyc.size() < 5; k++) cycle();
        check("rr_count", 32'(log_cyc.size()), 32'd5);
        if (log_cyc.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_owner", 32'(log_owner[k]), 32'(k % 4));
                check("rr_val",   32'(log_val[k]),   32'(16'd1 << (k % 4)));
                if (k > 0) check("rr_gap", 32'(log_cyc[k] - log_cyc[k-1]), 32'(HOLD + 2));
            end
        end

        // Reset in the middle of a hold
        cycle();
        req_drv     = '0;
        drop_on_ack = '1;
        #2 reset = 1'b1;
        #1;
        check("rst_led_start", 32'(bus.led_start), 32'd0);
        check("rst_ack",       32'(bus.ack),       32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_led_val",   32'(bus.led_val),   32'd0);
        check("rst_owner",     32'(bus.owner),     32'd0);
        repeat (2) cycle();
        #2 reset = 1'b0;
        n0 = log_cyc.size();
        repeat (20) cycle();
        check("no_start_after_reset", 32'(log_cyc.size()), 32'(n0));

        // Single grant of requester 2
        set_val(2, 16'hA5A5);
        req_drv = 4'b0100;
        cycle();
        check("single_start", 32'(bus.led_start), 32'd1);
        check("single_val",   32'(bus.led_val),   32'hA5A5);
        check("single_ack",   32'(bus.ack),       32'b0100);
        check("single_owner", 32'(bus.owner),     32'd2);
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        repeat (HOLD + 4) begin
            cycle();
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("single_busy_len", 32'(busy_cnt), 32'(HOLD + 1));

        // Hold blocking: requester 3 rises while requester 1's value is held
        set_val(1, 16'h1111);
        set_val(3, 16'h3333);
        req_drv[1] = 1'b1;
        cycle();
        check("blk_first_owner", 32'(bus.owner), 32'd1);
        g = cyc;
        cycle();
        req_drv[3] = 1'b1;
        got = 0;
        for (int k = 0; k < HOLD + 6 && got == 0; k++) begin
            cycle();
            if (bus.led_start === 1'b1) got = 1;
            else check("blk_held_val", 32'(bus.led_val), 32'h1111);
        end
        check("blk_grant_seen", 32'(got), 32'd1);
        check("blk_gap",        32'(cyc - g), 32'(HOLD + 2));
        check("blk_owner",      32'(bus.owner), 32'd3);
        check("blk_new_val",    32'(bus.led_val), 32'h3333);

        // Withdrawn request: req[2] pulses for one cycle during the hold
        cycle();
        n0   = log_cyc.size();
        seen = 0;
        set_val(2, 16'hBEEF);
        req_drv[2] = 1'b1;
        cycle();
        if (bus.ack[2] === 1'b1) seen = 1;
        req_drv[2] = 1'b0;
        repeat (HOLD + 6) begin
            cycle();
            if (bus.ack[2] === 1'b1) seen = 1;
        end
        check("wd_no_start", 32'(log_cyc.size()), 32'(n0));
        check("wd_no_ack2",  32'(seen), 32'd0);

        // Random requesters obeying the handshake, with one reset in the middle
        drop_on_ack = '0;
        n0 = log_cyc.size();
        for (int n = 0; n < 3000; n++) begin
            cycle();
            for (int i = 0; i < N_REQ; i++) begin
                if (req_drv[i]) begin
                    if (exp_ack[i]) begin
                        if ($urandom_range(1, 0) == 1) req_drv[i] = 1'b0;
                        else set_val(i, 16'($urandom));
                    end else if ($urandom_range(39, 0) == 0) begin
                        req_drv[i] = 1'b0;
                    end
                end else if ($urandom_range(5, 0) == 0) begin
                    set_val(i, 16'($urandom));
                    req_drv[i] = 1'b1;
                end
            end
            if (n == 1500) reset = 1'b1;
            if (n == 1503) reset = 1'b0;
        end
        check("random_activity", 32'(log_cyc.size() > n0 + 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/leds_arbiter.md
Name: leds_arbiter

Overview:
- Shares the single 16-bit board LED register (write strobe + 16-bit value) between N_REQ requesters, typically HLS-generated accelerator cores and a debug/status source.
- Arbitrates round-robin and issues one write strobe per grant to the LED register.
- Holds each granted value on the LEDs for a minimum number of cycles so it stays human-visible before another requester may overwrite it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OWNER_W, 2, width of owner index; must satisfy 2**OWNER_W >= N_REQ.
- HOLD_CYCLES, 1000, minimum cycles between consecutive LED writes; 0 disables holding.
- CNT_W, 16, hold counter width; HOLD_CYCLES < 2**CNT_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its ack.
- req_val  in  16*N_REQ  LED value per requester; requester i uses bits [16*i+15:16*i].
- ack  out  N_REQ  one-cycle pulse to the granted requester.
- led_start  out  1  one-cycle write strobe to the LED register.
- led_val  out  16  value written; valid when led_start=1, holds the last value otherwise.
- owner  out  OWNER_W  index of the last granted requester.
- busy  out  1  high in ISSUE and HOLD.

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, hold counter=0, ack=0, led_start=0, led_val=0, owner=0, busy=0. Asserting reset mid-HOLD or mid-ISSUE aborts immediately; no strobe is emitted on release.
- States: IDLE, ISSUE, HOLD. All outputs are registered.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: select the winner as the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ. Register its req_val slice and index, then go to ISSUE.
- ISSUE (exactly one cycle):
  - led_start=1, led_val=latched value, ack[winner]=1, owner=winner, busy=1.
  - rr_ptr <= winner+1, wrapping N_REQ-1 to 0.
  - Load the counter with HOLD_CYCLES. Next state is HOLD, or IDLE if HOLD_CYCLES=0.
- HOLD:
  - Counter decrements each cycle; busy=1; requests are ignored.
  - When the counter reaches 1, go to IDLE on the next edge. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- Latency and strobe spacing:
  - req seen in IDLE at edge t gives led_start/ack high during cycle t+1.
  - Minimum spacing between consecutive led_start pulses is HOLD_CYCLES+2 cycles (1 if HOLD_CYCLES=0 plus the IDLE cycle, i.e. 2).
- Requester handshake:
  - A requester must keep req and req_val stable until ack.
  - The value is sampled in the IDLE cycle of selection; changes after that are not reflected.
  - A requester dropping req before selection is never granted and never acked.
- Requester still high after ack: it is eligible again but gets lowest priority (rr_ptr moved past it).
- Simultaneous requests: strict rotation; no requester is granted twice while another requester stays continuously asserted.
- ack is one-hot or zero; it is never asserted outside ISSUE.
- The strobe is suitable to drive the LED register's start/value inputs directly.

Optional Feature:
- Macro: LEDS_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has fixed top priority in IDLE, regardless of rr_ptr.
  - A req[0] arriving during HOLD aborts the hold: next state is IDLE, and requester 0 is selected there.
  - Granting requester 0 does not modify rr_ptr.
  - Other requesters rotate round-robin among indices 1..N_REQ-1.
- Not defined: pure round-robin as specified above; HOLD is never aborted.

Test Plan:
- Reset check: reset=1 mid-HOLD -> all outputs 0, state IDLE. Release reset with req=0 -> no led_start for 20 cycles.
- Single grant: HOLD_CYCLES=4, req[2]=1, val2=16'hA5A5.
  - Cycle after sampling: led_start=1, led_val=A5A5, ack=4'b0100, owner=2.
  - busy stays high for 5 cycles total.
- Round robin: all four req held, values 0x0001/0x0002/0x0004/0x0008, HOLD_CYCLES=2 -> grants 0,1,2,3,0 with led_start pulses exactly 4 cycles apart.
- Hold blocking: grant req[1]; req[3] rises during HOLD -> req[3] granted only after HOLD ends; led_val keeps req[1]'s value until then.
- Withdrawn request: req[2] pulses for 1 cycle during HOLD and is gone by IDLE -> no ack[2], no led_start.
- With LEDS_ARB_PRIO0_EN: req[1] granted with HOLD_CYCLES=100; req[0] rises 10 cycles into HOLD -> led_start with val0 within 3 cycles, ack[0]=1, and rr_ptr still points to 2.
